// File: rtl/fifo_arb_pkg.sv
// Shared state encodings and width helper for the FIFO drain arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Channel selector: lowest-index urgent requester wins, else round-robin from rr_ptr.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] urgent,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [IDX_W-1:0]  pick,
  output logic              pick_valid
);

  logic [NUM_CH-1:0] hot;
  logic [IDX_W-1:0]  idx;

  assign hot = req & urgent;

  // Scans run high-to-low so the last hit (lowest offset) wins.
  // NUM_CH is a power of two, so the index add wraps naturally.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    if (|hot) begin
      pick_valid = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (hot[i]) pick = IDX_W'(i);
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = rr_ptr + IDX_W'(k);
        if (req[idx]) begin
          pick       = idx;
          pick_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains NUM_CH upstream FIFOs into one downstream FIFO, one pop per cycle, push one cycle later.
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 4,
  parameter  int CNT_WIDTH  = 16,
  localparam int GID_W      = clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH-1:0]            ch_almost_full,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]            ch_rd_en,
  input  logic                         dn_full,
  input  logic                         dn_almost_full,
  input  logic                         dn_almost_empty,
  output logic                         dn_wr_en,
  output logic [DATA_WIDTH-1:0]        dn_data,
  output logic [GID_W-1:0]             grant_id,
  output logic [1:0]                   state,
  output logic [CNT_WIDTH-1:0]         pushed_count
);

  arb_state_e cur, nxt;
  logic [GID_W-1:0] rr_ptr;
  logic [GID_W-1:0] pick;
  logic             pick_valid;
  logic             pop;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_word;

  assign ch_word = ch_data;
  assign state   = cur;

  rr_pick #(.NUM_CH(NUM_CH), .IDX_W(GID_W)) u_pick (
    .req        (~ch_empty),
    .urgent     (ch_almost_full),
    .rr_ptr     (rr_ptr),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  assign pop = (cur == ST_RUN) && enable && !dn_almost_full && !dn_full && pick_valid;

  always_comb begin
    ch_rd_en = '0;
    if (pop) ch_rd_en[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= ST_IDLE;
    else      cur <= nxt;
  end

  // Dropping enable beats every other transition.
  always_comb begin
    nxt = cur;
    unique case (cur)
      ST_IDLE:  if (enable) nxt = ST_RUN;
      ST_RUN:   if (!enable) nxt = ST_IDLE;
                else if (dn_almost_full) nxt = ST_PAUSE;
      ST_PAUSE: if (!enable) nxt = ST_IDLE;
                else if (dn_almost_empty && !dn_almost_full) nxt = ST_RUN;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      dn_wr_en     <= 1'b0;
      pushed_count <= '0;
    end else begin
      dn_wr_en <= pop;
      if (pop) begin
        rr_ptr   <= pick + 1'b1;
        grant_id <= pick;
      end
      if (dn_wr_en) pushed_count <= pushed_count + 1'b1;
    end
  end

  // The upstream buf_out holds the popped word during the push cycle.
  assign dn_data = dn_wr_en ? ch_word[grant_id] : '0;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Randomised bench: behavioural FIFOs around the arbiter plus a cycle-level reference model.
module tb_fifo_drain_arbiter;
  localparam int N = 4, DW = 4, CW = 5, GW = 2;
  localparam int DEPTH = 16, UP_AF = 12, DN_AF = 14, DN_AE = 3;

  logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic [N-1:0] ch_empty, ch_almost_full, ch_rd_en;
  logic [N*DW-1:0] ch_data;
  logic dn_full, dn_almost_full, dn_almost_empty, dn_wr_en;
  logic [DW-1:0] dn_data;
  logic [GW-1:0] grant_id;
  logic [1:0] state;
  logic [CW-1:0] pushed_count;

  fifo_drain_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_empty(ch_empty),
    .ch_almost_full(ch_almost_full), .ch_data(ch_data), .ch_rd_en(ch_rd_en),
    .dn_full(dn_full), .dn_almost_full(dn_almost_full), .dn_almost_empty(dn_almost_empty),
    .dn_wr_en(dn_wr_en), .dn_data(dn_data), .grant_id(grant_id), .state(state),
    .pushed_count(pushed_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] upq [N][$];
  logic [DW-1:0] upout [N];
  logic [DW-1:0] dnq [$];
  logic [DW-1:0] dnlog [$];

  // reference model: 0 idle, 1 run, 2 pause
  int mst, mptr, mgrant, mpend, mcnt;
  logic [DW-1:0] mword;
  int total = 0, bad = 0;

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task drive_flags();
    for (int i = 0; i < N; i++) begin
      ch_empty[i]       = (upq[i].size() == 0);
      ch_almost_full[i] = (upq[i].size() >= UP_AF);
      ch_data[i*DW +: DW] = upout[i];
    end
    dn_full         = (dnq.size() >= DEPTH);
    dn_almost_full  = (dnq.size() >= DN_AF);
    dn_almost_empty = (dnq.size() <= DN_AE);
  endtask

  function automatic int exp_pick();
    if (mst != 1 || !enable || dnq.size() >= DN_AF) return -1;
    for (int i = 0; i < N; i++)
      if (upq[i].size() >= UP_AF) return i;
    for (int k = 0; k < N; k++)
      if (upq[(mptr + k) % N].size() > 0) return (mptr + k) % N;
    return -1;
  endfunction

  task step(input int wr_pct, input int rd_pct);
    int p;
    logic [N-1:0] rd;
    logic wr;
    logic [DW-1:0] wd;
    bit dnaf, dnae;
    @(negedge clk);
    p = exp_pick();
    chk("ch_rd_en", ch_rd_en, (p < 0) ? 0 : (1 << p));
    chk("dn_wr_en", dn_wr_en, mpend);
    chk("dn_data", dn_data, mpend ? mword : 0);
    chk("state", state, mst);
    chk("grant_id", grant_id, mgrant);
    chk("pushed_count", pushed_count, mcnt);
    rd = ch_rd_en; wr = dn_wr_en; wd = dn_data;
    dnaf = dnq.size() >= DN_AF;
    dnae = dnq.size() <= DN_AE;
    mcnt  = (mcnt + mpend) % (1 << CW);
    mpend = (p >= 0);
    if (p >= 0) begin
      mword  = upq[p][0];
      mptr   = (p + 1) % N;
      mgrant = p;
    end
    if (mst != 0 && !enable) mst = 0;
    else if (mst == 0 && enable) mst = 1;
    else if (mst == 1 && dnaf) mst = 2;
    else if (mst == 2 && dnae && !dnaf) mst = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rd[i]) begin
        chk("pop_nonempty", upq[i].size() > 0, 1);
        if (upq[i].size() > 0) upout[i] = upq[i].pop_front();
      end
    if (wr) begin
      chk("dn_no_overflow", dnq.size() < DEPTH, 1);
      if (dnq.size() < DEPTH) dnq.push_back(wd);
      dnlog.push_back(wd);
    end
    if (dnq.size() > 0 && $urandom_range(99) < rd_pct) void'(dnq.pop_front());
    for (int i = 0; i < N; i++)
      if (upq[i].size() < DEPTH && $urandom_range(99) < wr_pct)
        upq[i].push_back(DW'($urandom));
    drive_flags();
  endtask

  task do_reset();
    rst = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < N; i++) begin
      upq[i].delete();
      upout[i] = '0;
    end
    dnq.delete();
    dnlog.delete();
    mst = 0; mptr = 0; mgrant = 0; mpend = 0; mcnt = 0; mword = '0;
    drive_flags();
    #1;
    chk("rst_state", state, 0);
    chk("rst_wr_en", dn_wr_en, 0);
    chk("rst_data", dn_data, 0);
    chk("rst_rd_en", ch_rd_en, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_count", pushed_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int found;
    int wr_pct, rd_pct;
    do_reset();

    // round-robin skips the empty channel
    upq[0].push_back(4'd1); upq[0].push_back(4'd2);
    upq[1].push_back(4'd3);
    upq[3].push_back(4'd4);
    drive_flags();
    enable = 1'b1;
    repeat (8) step(0, 0);
    chk("rr_len", dnlog.size(), 4);
    if (dnlog.size() == 4) begin
      chk("rr_w0", dnlog[0], 1);
      chk("rr_w1", dnlog[1], 3);
      chk("rr_w2", dnlog[2], 4);
      chk("rr_w3", dnlog[3], 2);
    end
    chk("rr_count", pushed_count, 4);

    // single channel back-to-back
    dnlog.delete();
    upq[2].push_back(4'd5); upq[2].push_back(4'd6); upq[2].push_back(4'd7);
    drive_flags();
    repeat (6) step(0, 0);
    chk("b2b_len", dnlog.size(), 3);
    if (dnlog.size() == 3) begin
      chk("b2b_w0", dnlog[0], 5);
      chk("b2b_w1", dnlog[1], 6);
      chk("b2b_w2", dnlog[2], 7);
    end
    chk("b2b_grant", grant_id, 2);

    // urgent channel jumps the round-robin order
    do_reset();
    for (int i = 0; i < UP_AF; i++) upq[1].push_back(4'd15);
    upq[0].push_back(4'd9);
    upq[2].push_back(4'd10);
    drive_flags();
    enable = 1'b1;
    repeat (6) step(0, 0);
    chk("urg_len", dnlog.size(), 4);
    if (dnlog.size() >= 3) begin
      chk("urg_w0", dnlog[0], 15);
      chk("urg_w1", dnlog[1], 10);
      chk("urg_w2", dnlog[2], 9);
    end

    // randomised traffic with backpressure phases and enable glitches
    wr_pct = 30; rd_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(3))
          0: rd_pct = 0;
          1: rd_pct = 20;
          2: rd_pct = 60;
          default: rd_pct = 100;
        endcase
        wr_pct = ($urandom_range(1) != 0) ? 40 : 10;
      end
      if (enable) begin
        if ($urandom_range(99) < 2) enable = 1'b0;
      end else if ($urandom_range(99) < 30) enable = 1'b1;
      step(wr_pct, rd_pct);
    end

    // reset while a push is in flight
    enable = 1'b1;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      step(50, 100);
      if (mpend != 0) found = 1;
    end
    chk("mid_rst_found", found, 1);
    if (found != 0) chk("pre_rst_wr_en", dn_wr_en, 1);
    do_reset();
    repeat (3) step(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
Round-robin scheduler that drains NUM_CH upstream fifo16 instances into one downstream fifo16.
- Pops at most one upstream FIFO per cycle and pushes the word downstream one cycle later.
- Honours downstream almost_full / almost_empty with pause/resume hysteresis.
- Gives priority to upstream channels reporting almost_full.

Parameters:
NUM_CH, 4, number of upstream FIFOs (fixed power of two, 2..8)
DATA_WIDTH, 4, word width, equal to fifo16 DATA_WIDTH
CNT_WIDTH, 16, width of pushed-word counter

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  1 = arbiter may schedule pops
ch_empty  in  NUM_CH  buf_empty of each upstream FIFO
ch_almost_full  in  NUM_CH  almost_full of each upstream FIFO
ch_data  in  NUM_CH*DATA_WIDTH  buf_out of each upstream FIFO, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
ch_rd_en  out  NUM_CH  one-hot-or-zero pop strobe to upstream FIFOs
dn_full  in  1  buf_full of downstream FIFO
dn_almost_full  in  1  almost_full of downstream FIFO
dn_almost_empty  in  1  almost_empty of downstream FIFO
dn_wr_en  out  1  push strobe to downstream FIFO
dn_data  out  DATA_WIDTH  data to downstream buf_in
grant_id  out  log2(NUM_CH)  channel of last pop
state  out  2  FSM state
pushed_count  out  CNT_WIDTH  words pushed since reset, wraps

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, rr_ptr=0, grant_id=0.
- dn_wr_en=0, dn_data=0, ch_rd_en=0, pushed_count=0.

FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10.
- IDLE -> RUN: enable=1.
- RUN -> PAUSE: dn_almost_full=1.
- PAUSE -> RUN: dn_almost_empty=1 and dn_almost_full=0.
- RUN or PAUSE -> IDLE: enable=0. This takes precedence over all other transitions.

Pop decision (combinational, from registered state plus current flags):
- Pop only when state==RUN, dn_almost_full=0, dn_full=0, enable=1, and some ch_empty[i]=0.
- Urgent pick: if any channel has ch_almost_full=1 and ch_empty=0, pick the lowest such index.
- Otherwise round-robin pick: first non-empty channel scanning from rr_ptr upward, wrapping at NUM_CH.
- On a pop: ch_rd_en[pick]=1; at the next edge rr_ptr<=pick+1 mod NUM_CH and grant_id<=pick.
- Never assert ch_rd_en to an empty channel. At most one ch_rd_en bit is high in any cycle.

Push stage (latency 1 cycle pop->push):
- dn_wr_en <= |ch_rd_en at each edge.
- dn_data is a combinational mux: ch_data[grant_id] when dn_wr_en=1, else 0.
- The downstream FIFO captures the word at the edge ending that cycle.
- Back-to-back pops, including the same channel twice, give one push per cycle with data in pop order.

pushed_count increments on each cycle with dn_wr_en=1 and wraps from 2^CNT_WIDTH-1 to 0.

Boundaries:
- dn_almost_full rising during a pending push: that push completes. The downstream almost_full threshold must leave at least one free entry.
- enable falling: no new pop from that cycle on; an in-flight push still completes.
- Reset mid-operation: any in-flight push is dropped, all outputs return to reset values immediately.
- All channels empty in RUN: stay in RUN, no strobes, rr_ptr held.

Decomposition:
Package fifo_arb_pkg holds:
- state encodings ST_IDLE, ST_RUN, ST_PAUSE;
- the function clog2 used for grant_id width.

Sub-module rr_pick (pure combinational):
- inputs: request vector, urgent vector, rr_ptr;
- outputs: pick index, pick_valid.

The FSM, push stage and counter stay in fifo_drain_arbiter.

Test Plan:
Setup: NUM_CH=4, DATA_WIDTH=4, four upstream fifo16 plus one downstream fifo16 (BUF_WIDTH=4).
- Reset: rst=0 then 1 with enable=0 -> all outputs 0, state=00. Assert rst=0 mid-RUN -> dn_wr_en drops to 0 the same cycle.
- Round-robin: preload ch0={1,2}, ch1={3}, ch2={}, ch3={4}; enable=1 -> downstream receives 1,3,4,2 on 4 consecutive cycles; pushed_count=4; ch_rd_en never hits ch2.
- Urgent: ch1 filled past its almost_full threshold, ch0 and ch2 holding one word each, rr_ptr=0 -> first pop is ch1, then rr continues from 2.
- Backpressure: downstream almost_full at 14 entries, almost_empty at 3 -> state goes to 10 with no further pops. Pop downstream to 3 entries -> state 01 and pops resume. dn_full is never exceeded and no word is lost or duplicated.
- Enable drop: deassert enable in the same cycle as a pop -> that word is still pushed, then state=00 and no strobes.
- Single channel back-to-back: ch2={5,6,7}, others empty -> pushes 5,6,7 on consecutive cycles, grant_id=2.
